// File: rtl/vpu_lane_issuer.sv
// VPU lane issuer: accepts one host request, classifies the opcode, launches
// a single lane operation, waits (with timeout) for its result and returns a
// response with an error code.

package VPU_PKG;
  localparam int SRC_OPERAND_CNT = 3;
  localparam int OPERAND_WIDTH   = 32;

  typedef logic [3:0] vpu_h2d_req_opcode_t;

  localparam vpu_h2d_req_opcode_t OP_FADD   = 4'h0;
  localparam vpu_h2d_req_opcode_t OP_FSUB   = 4'h1;
  localparam vpu_h2d_req_opcode_t OP_FMUL   = 4'h2;
  localparam vpu_h2d_req_opcode_t OP_FDIV   = 4'h3;
  localparam vpu_h2d_req_opcode_t OP_FMAX2  = 4'h4;
  localparam vpu_h2d_req_opcode_t OP_FAVG2  = 4'h5;
  localparam vpu_h2d_req_opcode_t OP_FADD3  = 4'h6;
  localparam vpu_h2d_req_opcode_t OP_FMAX3  = 4'h7;
  localparam vpu_h2d_req_opcode_t OP_FAVG3  = 4'h8;
  localparam vpu_h2d_req_opcode_t OP_FSQRT  = 4'h9;
  localparam vpu_h2d_req_opcode_t OP_FEXP   = 4'hA;
  localparam vpu_h2d_req_opcode_t OP_FRECIP = 4'hB;
endpackage

module vpu_lane_issuer
  import VPU_PKG::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                                             clk,
  input  logic                                             rst,
  input  logic                                             req_valid_i,
  output logic                                             req_ready_o,
  input  vpu_h2d_req_opcode_t                              req_opcode_i,
  input  logic [SRC_OPERAND_CNT-1:0][OPERAND_WIDTH-1:0]    req_operand_i,
  input  logic [SRC_OPERAND_CNT-1:0]                       req_operand_valid_i,
  output logic                                             lane_start_o,
  output vpu_h2d_req_opcode_t                              lane_opcode_o,
  output logic [SRC_OPERAND_CNT-1:0][OPERAND_WIDTH-1:0]    lane_operand_o,
  output logic [SRC_OPERAND_CNT-1:0]                       lane_operand_valid_o,
  input  logic [OPERAND_WIDTH-1:0]                         lane_dout_i,
  input  logic                                             lane_done_i,
  output logic                                             rsp_valid_o,
  input  logic                                             rsp_ready_i,
  output logic [OPERAND_WIDTH-1:0]                         rsp_data_o,
  output logic [1:0]                                       rsp_err_o
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_ILLEGAL = 2'b01;
  localparam logic [1:0] ERR_MISSING = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;
  localparam logic [8:0] TMO         = 9'(TIMEOUT_CYCLES);

  state_t state, state_nxt;

  vpu_h2d_req_opcode_t                           op_q;
  logic [SRC_OPERAND_CNT-1:0][OPERAND_WIDTH-1:0] opnd_q;
  logic [SRC_OPERAND_CNT-1:0]                    vld_q;
  logic [7:0]                                    cnt;

  // Operands each opcode needs; all-zero marks an illegal opcode.
  function automatic logic [SRC_OPERAND_CNT-1:0] need_mask(vpu_h2d_req_opcode_t op);
    case (op)
      OP_FSQRT, OP_FEXP, OP_FRECIP:                        need_mask = 3'b001;
      OP_FADD, OP_FSUB, OP_FMUL, OP_FDIV, OP_FMAX2,
      OP_FAVG2:                                            need_mask = 3'b011;
      OP_FADD3, OP_FMAX3, OP_FAVG3:                        need_mask = 3'b111;
      default:                                             need_mask = 3'b000;
    endcase
  endfunction

  logic [SRC_OPERAND_CNT-1:0] need;
  logic accept, illegal, missing, tmo;

  assign need    = need_mask(req_opcode_i);
  assign accept  = req_valid_i & req_ready_o;
  assign illegal = (need == '0);
  assign missing = ((req_operand_valid_i & need) != need);
  // Timeout fires in the WAIT cycle that would bring the counter to the limit.
  assign tmo     = ({1'b0, cnt} + 9'd1 == TMO);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; a lane done coincident with the timeout still counts as done.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (accept) state_nxt = (illegal || missing) ? RESP : ISSUE;
      ISSUE: state_nxt = WAIT;
      WAIT:  if (lane_done_i || tmo) state_nxt = RESP;
      RESP:  if (rsp_ready_i) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from state; lane bus is only live while an op is in flight.
  always_comb begin
    req_ready_o          = (state == IDLE) && !rst;
    lane_start_o         = (state == ISSUE);
    rsp_valid_o          = (state == RESP);
    lane_opcode_o        = '0;
    lane_operand_o       = '0;
    lane_operand_valid_o = '0;
    if (state == ISSUE || state == WAIT) begin
      lane_opcode_o        = op_q;
      lane_operand_o       = opnd_q;
      lane_operand_valid_o = vld_q;
    end
  end

  // Request capture, wait counter and response registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q       <= '0;
      opnd_q     <= '0;
      vld_q      <= '0;
      cnt        <= '0;
      rsp_data_o <= '0;
      rsp_err_o  <= ERR_OK;
    end else begin
      case (state)
        IDLE: if (accept) begin
          op_q   <= req_opcode_i;
          opnd_q <= req_operand_i;
          vld_q  <= req_operand_valid_i;
          if (illegal) begin
            rsp_data_o <= '0;
            rsp_err_o  <= ERR_ILLEGAL;
          end else if (missing) begin
            rsp_data_o <= '0;
            rsp_err_o  <= ERR_MISSING;
          end
        end
        ISSUE: cnt <= '0;
        WAIT: begin
          if (lane_done_i) begin
            rsp_data_o <= lane_dout_i;
            rsp_err_o  <= ERR_OK;
          end else begin
            cnt <= cnt + 8'd1;
            if (tmo) begin
              rsp_data_o <= '0;
              rsp_err_o  <= ERR_TIMEOUT;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
